// File: rtl/if_types_pkg.sv
// Shared OBI interface types plus the storage entry used by the response FIFO.
package if_types_pkg;

  localparam int unsigned ObiDataWidth = 64;
  localparam int unsigned ObiIdWidth   = 4;

  typedef struct packed {
    logic [ObiDataWidth-1:0] rdata;
    logic                    err;
    logic [ObiIdWidth-1:0]   rid;
  } obi_r_chan_t;

  typedef struct packed {
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

  // One queued R-channel response as held in the FIFO storage.
  typedef struct packed {
    logic [ObiDataWidth-1:0] rdata;
    logic                    err;
    logic [ObiIdWidth-1:0]   rid;
  } obi_rsp_entry_t;

  // Elaboration-time guard: depth must be a power of two, at least 2.
  function automatic bit depth_is_valid(int unsigned depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/obi_rsp_fifo.sv
// In-order OBI read-response buffer between the cache controller and the OBI master port.
// Back-pressures the controller on occupancy only and flags pushes into a full buffer.
module obi_rsp_fifo
  import if_types_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   rdata_in,
  input  logic                    err_in,
  input  logic [ID_WIDTH-1:0]     rid_in,
  output obi_rsp_t                obi_resp,
  input  logic                    rready_in,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

  if (!depth_is_valid(DEPTH)) begin : g_bad_depth
    $error("obi_rsp_fifo: DEPTH must be a power of two >= 2");
  end
  if (DATA_WIDTH != ObiDataWidth || ID_WIDTH != ObiIdWidth) begin : g_bad_width
    $error("obi_rsp_fifo: DATA_WIDTH/ID_WIDTH must match if_types_pkg");
  end

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  obi_rsp_entry_t  mem_q [DEPTH];
  obi_rsp_entry_t  wr_entry;
  logic            push, pop;

  // Handshakes: in_ready looks at the registered count only, so a pop never frees a slot
  // for a push in the same cycle.
  always_comb begin
    in_ready = (count_q < FullCount);
    push     = in_valid & in_ready;
    pop      = obi_resp.rvalid & rready_in;
    wr_entry = '{rdata: rdata_in, err: err_in, rid: rid_in};
  end

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    if (in_valid && !in_ready) overflow_d = 1'b1;
  end

  // Control state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; the empty-forcing on the output hides stale contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  // Present the head entry, forced to zero while empty.
  always_comb begin
    obi_resp = '0;
    if (count_q != '0) begin
      obi_resp.rvalid  = 1'b1;
      obi_resp.r.rdata = mem_q[rd_ptr_q].rdata;
      obi_resp.r.err   = mem_q[rd_ptr_q].err;
      obi_resp.r.rid   = mem_q[rd_ptr_q].rid;
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;

endmodule
